mat4_xform_ctrl: RTL and testbench

MAT4_XFORM_CTRL -- requirements
Module: mat4_xform_ctrl

---
 rtl/q88_pkg.sv | 19 +
 rtl/mat4_xform_ctrl.sv | 98 +++++++++
 tb/tb_mat4_xform_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q88_pkg.sv
// Shared Q8.8 constants, vec4 lane indices and the transform controller state type.
package q88_pkg;

   localparam logic [15:0] ONE = 16'h0100;

   // Lane order inside a packed {w,z,y,x} vector; x occupies the low 16 bits.
   localparam logic [1:0] LANE_X = 2'd0;
   localparam logic [1:0] LANE_Y = 2'd1;
   localparam logic [1:0] LANE_Z = 2'd2;
   localparam logic [1:0] LANE_W = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } xform_state_e;

endpackage

// File: rtl/mat4_xform_ctrl.sv
// 4x4 Q8.8 matrix * vec4 transform controller sequencing one row per dot4 operation.
module mat4_xform_ctrl
   import q88_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mat_we,
   input  logic [3:0]  mat_addr,
   input  logic [15:0] mat_wdata,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_vec,
   output logic        d_start,
   output logic [63:0] d_v1,
   output logic [63:0] d_v2,
   input  logic        d_done,
   input  logic [15:0] d_result
);

   logic [15:0]  m_q [16];
   xform_state_e state_q, state_d;
   logic [1:0]   row_q, row_d;
   logic [63:0]  v_q, v_d;
   logic [63:0]  out_q, out_d;
   logic [63:0]  m_row;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 16; i++) begin
            m_q[i[3:0]] <= (i[1:0] == i[3:2]) ? ONE : '0;
         end
      end else if (mat_we && state_q == S_IDLE) begin
         m_q[mat_addr] <= mat_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         v_q     <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         v_q     <= v_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      v_d     = v_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               v_d     = in_vec;
               row_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // d_done is only meaningful here; a stale level elsewhere belongs to an earlier op.
            if (d_done) begin
               out_d[{row_q, 4'b0000} +: 16] = d_result;
               if (row_q == 2'd3) begin
                  state_d = S_OUT;
               end else begin
                  row_d   = row_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // M cannot change outside IDLE, so the selected row stays stable for the whole dot4 op.
   assign m_row = {m_q[{row_q, LANE_W}], m_q[{row_q, LANE_Z}],
                   m_q[{row_q, LANE_Y}], m_q[{row_q, LANE_X}]};

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_vec   = out_q;
   assign d_start   = (state_q == S_ISSUE);
   assign d_v1      = (state_q == S_ISSUE || state_q == S_WAIT) ? m_row : '0;
   assign d_v2      = v_q;

endmodule

// File: tb/tb_mat4_xform_ctrl.sv
// Bench for mat4_xform_ctrl: behavioural dot4 with programmable latency plus a Q8.8 reference model.
module tb_mat4_xform_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mat_we = 1'b0;
   logic [3:0]  mat_addr = '0;
   logic [15:0] mat_wdata = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_vec = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_vec;
   logic        d_start;
   logic [63:0] d_v1, d_v2;
   logic        d_done = 1'b0;
   logic [15:0] d_result = '0;

   mat4_xform_ctrl dut (
      .clk(clk), .reset(reset), .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .d_start(d_start), .d_v1(d_v1), .d_v2(d_v2), .d_done(d_done), .d_result(d_result)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stimulus knobs set by the main sequence, applied to the DUT inputs a little after each edge.
   int          lat = 1;
   bit          rdy_rand = 1'b0;
   bit          rdy_force = 1'b1;
   bit          wr_rand = 1'b0;
   logic        wf_we = 1'b0;
   logic [3:0]  wf_addr = '0;
   logic [15:0] wf_data = '0;

   always @(posedge clk) begin
      #2;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      if (wr_rand) begin
         mat_we    = ($urandom_range(0, 1) == 1);
         mat_addr  = 4'($urandom);
         mat_wdata = 16'($urandom);
      end else begin
         mat_we    = wf_we;
         mat_addr  = wf_addr;
         mat_wdata = wf_data;
      end
   end

   function automatic logic [15:0] dot_q88(input logic [63:0] a, input logic [63:0] b);
      longint s = 0;
      for (int i = 0; i < 4; i++)
         s += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
      s = s >>> 8;
      return s[15:0];
   endfunction

   // Behavioural dot4: result appears 'lat' cycles after start; start clears a prior done.
   int          dcnt = 0;
   logic [15:0] dres = '0;
   always @(posedge clk) begin
      if (d_start === 1'b1) begin
         dres = dot_q88(d_v1, d_v2);
         dcnt = lat - 1;
         if (lat == 1) begin
            d_done   <= 1'b1;
            d_result <= dres;
         end else begin
            d_done <= 1'b0;
         end
      end else if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            d_done   <= 1'b1;
            d_result <= dres;
         end
      end
   end

   // Reference: matrix mirror plus a queue of expected results for vertices in flight.
   logic [15:0] mm [16];
   logic [63:0] expq [$];

   function automatic logic [63:0] model_xform(input logic [63:0] v);
      logic [63:0] r, row;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) row[j*16 +: 16] = mm[i*4 + j];
         r[i*16 +: 16] = dot_q88(row, v);
      end
      return r;
   endfunction

   bit          prev_start = 1'b0;
   bit          op_act = 1'b0;
   logic [63:0] op1, op2;
   bit          stall = 1'b0;
   logic [63:0] held;
   int          busy = 0;

   always @(negedge clk) begin
      bit idle;
      if (reset) begin
         expq.delete();
         for (int i = 0; i < 16; i++) mm[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
         prev_start = 1'b0;
         op_act     = 1'b0;
         stall      = 1'b0;
         busy       = 0;
      end else begin
         idle = (expq.size() == 0);
         chk("in_ready", 64'(in_ready), 64'(idle));
         if (idle) chk("out_valid_idle", 64'(out_valid), 64'd0);
         if (idle) chk("d_start_idle", 64'(d_start), 64'd0);
         if (prev_start) chk("d_start_pulse", 64'(d_start), 64'd0);
         if (op_act && !d_start) begin
            chk("d_v1_stable", d_v1, op1);
            chk("d_v2_stable", d_v2, op2);
            if (d_done) op_act = 1'b0;
         end
         if (d_start) begin
            op1 = d_v1;
            op2 = d_v2;
            op_act = 1'b1;
         end
         prev_start = d_start;
         if (stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_vec", out_vec, held);
         end
         stall = out_valid && !out_ready;
         held  = out_vec;
         if (mat_we && idle) mm[mat_addr] = mat_wdata;
         if (out_valid && !idle) begin
            chk("out_vec", out_vec, expq[0]);
            if (out_ready) begin
               void'(expq.pop_front());
               busy = 0;
            end
         end
         if (in_valid && idle) expq.push_back(model_xform(in_vec));
         if (expq.size() != 0) busy++;
         if (busy > 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL watchdog: vertex outstanding %0d cycles, required <= 1000", busy);
            expq.delete();
            busy = 0;
         end
      end
   end

   task automatic send(input logic [63:0] v);
      int k = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_vec   = v;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 2000);
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [63:0] v, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 1000);
      if (!out_valid) chk("out_timeout", 64'(out_valid), 64'd1);
      v = out_vec;
   endtask

   task automatic wait_start();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!d_start && k < 200);
      if (!d_start) chk("start_timeout", 64'(d_start), 64'd1);
   endtask

   task automatic mwrite(input logic [3:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      wf_we = 1'b1; wf_addr = a; wf_data = d;
      @(posedge clk); #1;
      wf_we = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_vec", out_vec, 64'd0);
      chk("rst_d_start", 64'(d_start), 64'd0);
      chk("rst_d_v1", d_v1, 64'd0);
      chk("rst_d_v2", d_v2, 64'd0);
   endtask

   initial begin
      logic [63:0] v;
      int          k;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset();

      // Identity matrix, dot4 latency 1.
      lat = 1;
      send(64'h0100_0300_0200_0100);
      wait_out(v, k);
      chk("lat_identity", 64'(k), 64'd9);
      chk("vec_identity", v, 64'h0100_0300_0200_0100);

      // M[0][3] = 5.0 folds w into x.
      mwrite(4'd3, 16'h0500);
      send(64'h0100_0000_0000_0100);
      wait_out(v, k);
      chk("vec_m03", v, 64'h0100_0000_0000_0600);

      // Output back-pressure.
      @(posedge clk); #1 rdy_force = 1'b0;
      send(64'h0000_0000_0100_0200);
      wait_out(v, k);
      chk("vec_stall", v, 64'h0000_0000_0100_0200);
      repeat (5) begin
         @(negedge clk);
         chk("stall_hold_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1 rdy_force = 1'b1;
      @(negedge clk);
      chk("xfer_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      chk("post_xfer_in_ready", 64'(in_ready), 64'd1);
      chk("post_xfer_valid", 64'(out_valid), 64'd0);

      // Matrix write while busy is dropped.
      mwrite(4'd3, 16'h0000);
      lat = 8;
      send(64'h0000_0000_0000_0300);
      wait_start();
      mwrite(4'd0, 16'h0200);
      wait_out(v, k);
      chk("vec_busy_write", v, 64'h0000_0000_0000_0300);
      send(64'h0000_0000_0000_0100);
      wait_out(v, k);
      chk("vec_after_drop", v, 64'h0000_0000_0000_0100);

      // Reset in the middle of row 2 with a slow dot4.
      lat = 20;
      send(64'h0400_0300_0200_0100);
      repeat (3) wait_start();
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk_reset();
      repeat (30) @(negedge clk);
      lat = 1;
      send(64'h0001_0002_0003_0004);
      wait_out(v, k);
      chk("lat_after_reset", 64'(k), 64'd9);
      chk("vec_after_reset", v, 64'h0001_0002_0003_0004);

      // Randomized matrices, vectors, latencies and back-pressure.
      rdy_rand = 1'b1;
      wr_rand  = 1'b1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         lat = $urandom_range(1, 20);
         send({$urandom, $urandom});
      end
      k = 0;
      while (expq.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("drain", 64'(expq.size()), 64'd0);
      rdy_rand = 1'b0;
      wr_rand  = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
